// File: rtl/rd_req_split_sched_pkg.sv
// Shared DMA head layout, widths and MRRS decode for the read-request splitter.
package rd_req_split_sched_pkg;

    localparam int DMA_HEAD_W    = 128;
    localparam int DMA_LEN_WIDTH = 13;

    localparam int HEAD_ADDR_MSB = 95;
    localparam int HEAD_ADDR_LSB = 32;
    localparam int HEAD_LEN_MSB  = 12;
    localparam int HEAD_LEN_LSB  = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } split_state_t;

    typedef struct packed {
        logic [31:0]              rsvd;
        logic [63:0]              addr;
        logic [18:0]              pad;
        logic [DMA_LEN_WIDTH-1:0] len;
    } dma_head_t;

    // Codes above 5 clamp to 4096 bytes.
    function automatic logic [DMA_LEN_WIDTH-1:0] mrrs_bytes(input logic [2:0] code);
        logic [2:0] c;
        c = (code > 3'd5) ? 3'd5 : code;
        return 13'd128 << c;
    endfunction

endpackage

// File: rtl/rd_req_split_sched_fifo.sv
// Generic synchronous FIFO, power-of-two depth, show-ahead read data.
// Latency: written word visible at rdata the cycle after the write.
// Backpressure: writes ignored when full, reads ignored when empty.
module rd_req_split_sched_fifo #(
    parameter int DSIZE = 1,
    parameter int ASIZE = 4
) (
    input  logic             dma_clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rd_en,
    output logic [DSIZE-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [ASIZE:0]   count
);

    logic [DSIZE-1:0] mem [2**ASIZE];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic             push;
    logic             pop;

    assign count = wptr - rptr;
    assign full  = count[ASIZE];
    assign empty = (wptr == rptr);
    assign rdata = mem[rptr[ASIZE-1:0]];
    assign push  = wr_en & ~full;
    assign pop   = rd_en & ~empty;

    always_ff @(posedge dma_clk) begin
        if (push) begin
            mem[wptr[ASIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge dma_clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/rd_req_split_sched.sv
// Splits DMA read requests into MRRS-bounded, MRRS-aligned sub-requests; flags the final response.
// Latency: first sub-request the cycle after accept, then one per cycle; next accept after the last one.
// Backpressure: holds sub-request while sub_req_ready=0; stalls when the flag FIFO is full.
module rd_req_split_sched
    import rd_req_split_sched_pkg::*;
#(
    parameter int SUB_DEPTH_LOG = 6
) (
    input  logic                    dma_clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DMA_HEAD_W-1:0]   req_head,
    input  logic [2:0]              max_rd_req_sz,
    output logic                    sub_req_valid,
    input  logic                    sub_req_ready,
    output logic [DMA_HEAD_W-1:0]   sub_req_head,
    output logic                    sub_req_last,
    input  logic                    rsp_valid,
    input  logic                    rsp_ready,
    input  logic                    rsp_last,
    output logic                    emit,
    output logic [SUB_DEPTH_LOG:0]  sub_outstanding,
    output logic                    err_unexp_rsp
);

    split_state_t             state;
    split_state_t             state_nxt;
    logic [63:0]              cur_addr;
    logic [DMA_LEN_WIDTH-1:0] rem;
    logic [DMA_LEN_WIDTH-1:0] mrrs_b;
    logic [DMA_LEN_WIDTH-1:0] room;
    logic [DMA_LEN_WIDTH-1:0] chunk;
    dma_head_t                sub_hdr;
    logic                     accept;
    logic                     sub_fire;
    logic                     flag_full;
    logic                     flag_empty;
    logic                     flag_head;
    logic                     rsp_eop;
    logic                     unused_head_bits;

    assign unused_head_bits = ^{req_head[DMA_HEAD_W-1:HEAD_ADDR_MSB+1],
                                req_head[HEAD_ADDR_LSB-1:HEAD_LEN_MSB+1]};

    // Bytes left before the next MRRS-aligned boundary; mrrs_b is a power of two.
    assign room  = mrrs_b - (cur_addr[DMA_LEN_WIDTH-1:0] & (mrrs_b - 1'b1));
    assign chunk = (rem < room) ? rem : room;

    assign accept   = req_valid & req_ready;
    assign sub_fire = sub_req_valid & sub_req_ready;

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        sub_req_valid = 1'b0;
        sub_req_last  = 1'b0;
        sub_hdr       = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ST_SPLIT;
            end
            ST_SPLIT: begin
                sub_req_valid = ~flag_full;
                sub_req_last  = (rem <= chunk);
                sub_hdr.addr  = cur_addr;
                sub_hdr.len   = chunk;
                if (sub_req_valid && sub_req_ready && sub_req_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign sub_req_head = sub_hdr;

    always_ff @(posedge dma_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // MRRS is captured at accept only, so in-flight splitting ignores later changes.
    always_ff @(posedge dma_clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr <= '0;
            rem      <= '0;
            mrrs_b   <= '0;
        end else if (accept) begin
            cur_addr <= req_head[HEAD_ADDR_MSB:HEAD_ADDR_LSB];
            rem      <= req_head[HEAD_LEN_MSB:HEAD_LEN_LSB];
            mrrs_b   <= mrrs_bytes(max_rd_req_sz);
        end else if (sub_fire) begin
            cur_addr <= cur_addr + 64'(chunk);
            rem      <= rem - chunk;
        end
    end

    assign rsp_eop       = rsp_valid & rsp_ready & rsp_last;
    assign err_unexp_rsp = rsp_eop & flag_empty;
    assign emit          = ~flag_empty & flag_head;

    rd_req_split_sched_fifo #(
        .DSIZE (1),
        .ASIZE (SUB_DEPTH_LOG)
    ) u_flag_fifo (
        .dma_clk (dma_clk),
        .rst_n   (rst_n),
        .wr_en   (sub_fire),
        .wdata   (sub_req_last),
        .rd_en   (rsp_eop),
        .rdata   (flag_head),
        .full    (flag_full),
        .empty   (flag_empty),
        .count   (sub_outstanding)
    );

endmodule

// File: tb/tb_rd_req_split_sched.sv
// Randomized bench for rd_req_split_sched against a queue-based split/response model.
module tb_rd_req_split_sched;

    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;

    logic          dma_clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [127:0]  req_head;
    logic [2:0]    max_rd_req_sz;
    logic          sub_req_valid;
    logic          sub_req_ready;
    logic [127:0]  sub_req_head;
    logic          sub_req_last;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_last;
    logic          emit;
    logic [DL:0]   sub_outstanding;
    logic          err_unexp_rsp;

    always #5 dma_clk = ~dma_clk;

    rd_req_split_sched #(.SUB_DEPTH_LOG(DL)) dut (
        .dma_clk         (dma_clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_head        (req_head),
        .max_rd_req_sz   (max_rd_req_sz),
        .sub_req_valid   (sub_req_valid),
        .sub_req_ready   (sub_req_ready),
        .sub_req_head    (sub_req_head),
        .sub_req_last    (sub_req_last),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_last        (rsp_last),
        .emit            (emit),
        .sub_outstanding (sub_outstanding),
        .err_unexp_rsp   (err_unexp_rsp)
    );

    typedef struct {
        logic [63:0] addr;
        int          len;
        bit          last;
    } piece_t;

    int             total = 0;
    int             bad   = 0;
    piece_t         exp_q[$];
    bit             oq[$];
    logic [128:0]   hs_log[$];
    int             hs_cnt = 0;
    int             rdy_pct = 100;
    int             rsp_pct = 0;
    bit             rsp_manual = 0;
    bit             mrrs_jitter = 0;

    task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [128:0] mk(input logic [63:0] a, input int len, input bit last);
        return {last, 32'd0, a, 19'd0, 13'(len)};
    endfunction

    // Reference split: walk the range in MRRS-sized aligned windows using division.
    task automatic model_split(input logic [63:0] addr, input int len, input int sz);
        longint unsigned a;
        longint unsigned mb;
        longint unsigned bnd;
        int              rem;
        int              c;
        piece_t          p;
        a   = addr;
        rem = len;
        mb  = 128 << ((sz > 5) ? 5 : sz);
        do begin
            bnd = (a / mb + 1) * mb;
            c   = (longint'(rem) < longint'(bnd - a)) ? rem : int'(bnd - a);
            p.addr = a;
            p.len  = c;
            p.last = (rem == c);
            exp_q.push_back(p);
            a   += c;
            rem -= c;
        end while (rem > 0);
    endtask

    task automatic chk_rst();
        check("rst_req_ready", req_ready, 1);
        check("rst_sub_vld", sub_req_valid, 0);
        check("rst_sub_last", sub_req_last, 0);
        check("rst_sub_head", sub_req_head, 0);
        check("rst_emit", emit, 0);
        check("rst_outstanding", sub_outstanding, 0);
        check("rst_err", err_unexp_rsp, 0);
    endtask

    // One cycle: drive at posedge+1, check against the model, then advance the model at the edge.
    task automatic step(input bit send);
        bit           evt;
        bit           hs;
        logic [127:0] eh;
        req_valid = send ? 1'b1 : ((exp_q.size() > 0) ? 1'($urandom_range(1)) : 1'b0);
        sub_req_ready = ($urandom_range(99) < rdy_pct);
        if (!rsp_manual) begin
            rsp_valid = ($urandom_range(99) < rsp_pct);
            rsp_ready = ($urandom_range(3) != 0);
            rsp_last  = 1'($urandom_range(1));
        end
        if (mrrs_jitter && !send) max_rd_req_sz = 3'($urandom_range(7));
        #1;
        evt = rsp_valid && rsp_ready && rsp_last;
        check("req_ready", req_ready, exp_q.size() == 0);
        check("emit", emit, (oq.size() > 0) && oq[0]);
        check("outstanding", sub_outstanding, oq.size());
        check("err_unexp", err_unexp_rsp, evt && (oq.size() == 0));
        hs = 1'b0;
        if (exp_q.size() > 0) begin
            check("sub_vld", sub_req_valid, oq.size() < DEPTH);
            if (oq.size() < DEPTH) begin
                eh = {32'd0, exp_q[0].addr, 19'd0, 13'(exp_q[0].len)};
                check("sub_head", sub_req_head, eh);
                check("sub_last", sub_req_last, exp_q[0].last);
                hs = sub_req_ready;
            end
        end else begin
            check("sub_vld_idle", sub_req_valid, 0);
        end
        if (hs) hs_log.push_back({sub_req_last, sub_req_head});
        @(posedge dma_clk);
        if (evt && oq.size() > 0) void'(oq.pop_front());
        if (hs) begin
            oq.push_back(exp_q[0].last);
            void'(exp_q.pop_front());
            hs_cnt++;
        end
        #1;
    endtask

    task automatic send_req(input logic [63:0] a, input int len, input int sz);
        max_rd_req_sz = 3'(sz);
        req_head = {32'($urandom), a, 19'($urandom), 13'(len)};
        step(1'b1);
        req_valid = 1'b0;
        model_split(a, len, sz);
    endtask

    task automatic run_pieces(input int bound);
        int n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            step(1'b0);
            n++;
        end
        check("pieces_done", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic drain();
        int n = 0;
        int save = rsp_pct;
        rsp_manual = 1'b0;
        rsp_pct = 100;
        while (oq.size() > 0 && n < 500) begin
            step(1'b0);
            n++;
        end
        check("drain_done", oq.size(), 0);
        rsp_pct = save;
        rsp_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_head = '0;
        max_rd_req_sz = '0;
        sub_req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_ready = 1'b0;
        rsp_last = 1'b0;
        #2;
        chk_rst();
        repeat (3) @(posedge dma_clk);
        #1;
        rst_n = 1'b1;

        // 512B MRRS, three back-to-back pieces
        rdy_pct = 100;
        rsp_pct = 0;
        hs_log.delete();
        hs_cnt = 0;
        send_req(64'h1000, 1300, 2);
        repeat (3) step(1'b0);
        check("t1_count", hs_cnt, 3);
        check("t1_p0", hs_log[0], mk(64'h1000, 512, 0));
        check("t1_p1", hs_log[1], mk(64'h1200, 512, 0));
        check("t1_p2", hs_log[2], mk(64'h1400, 276, 1));

        // Three 2-beat responses; only the last one is the final piece
        rsp_manual = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < 2; b++) begin
                rsp_valid = 1'b1;
                rsp_ready = 1'b1;
                rsp_last  = (b == 1);
                #1;
                check("es_emit", emit, r == 2);
                check("es_outstanding", sub_outstanding, 3 - r);
                step(1'b0);
            end
        end
        rsp_valid = 1'b0;
        rsp_manual = 1'b0;
        #1;
        check("es_outstanding_end", sub_outstanding, 0);

        // Unaligned start at 128B MRRS
        hs_log.delete();
        send_req(64'h0FF0, 40, 0);
        run_pieces(20);
        check("t2_p0", hs_log[0], mk(64'h0FF0, 16, 0));
        check("t2_p1", hs_log[1], mk(64'h1000, 24, 1));
        drain();

        // Flag FIFO full stalls issue; one eop frees a slot next cycle
        rsp_pct = 0;
        hs_cnt = 0;
        send_req(64'h4000, 4096, 0);
        repeat (10) step(1'b0);
        check("bp_count", hs_cnt, DEPTH);
        check("bp_vld", sub_req_valid, 0);
        rsp_manual = 1'b1;
        rsp_valid = 1'b1;
        rsp_ready = 1'b1;
        rsp_last  = 1'b1;
        hs_cnt = 0;
        step(1'b0);
        check("bp_eop_cycle", hs_cnt, 0);
        rsp_valid = 1'b0;
        step(1'b0);
        check("bp_resume", hs_cnt, 1);
        rsp_manual = 1'b0;
        rsp_pct = 50;
        rdy_pct = 70;
        run_pieces(2000);
        drain();

        // Zero-length request
        rdy_pct = 100;
        rsp_pct = 0;
        hs_log.delete();
        send_req(64'h2000, 0, 3);
        run_pieces(20);
        check("len0_n", hs_log.size(), 1);
        check("len0_p0", hs_log[0], mk(64'h2000, 0, 1));
        drain();

        // Response eop with nothing outstanding
        rsp_manual = 1'b1;
        rsp_valid = 1'b1;
        rsp_ready = 1'b1;
        rsp_last  = 1'b1;
        #1;
        check("err_pulse", err_unexp_rsp, 1);
        check("err_emit", emit, 0);
        step(1'b0);
        rsp_valid = 1'b0;
        #1;
        check("err_clear", err_unexp_rsp, 0);
        check("err_outstanding", sub_outstanding, 0);
        rsp_manual = 1'b0;

        // MRRS raised mid-split must not change piece sizes
        hs_log.delete();
        rsp_pct = 60;
        send_req(64'h0, 1024, 0);
        max_rd_req_sz = 3'd5;
        run_pieces(200);
        check("mrrs_hold_n", hs_log.size(), 8);
        for (int i = 0; i < hs_log.size(); i++) check("mrrs_hold_len", hs_log[i][12:0], 128);
        drain();

        // Reset after two of three pieces
        rsp_pct = 0;
        rdy_pct = 100;
        send_req(64'h1000, 1300, 2);
        step(1'b0);
        step(1'b0);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk_rst();
        exp_q.delete();
        oq.delete();
        repeat (2) @(posedge dma_clk);
        #1;
        rst_n = 1'b1;
        hs_log.delete();
        send_req(64'h5F80, 700, 1);
        run_pieces(50);
        check("post_rst_n", hs_log.size(), 4);
        check("post_rst_p0", hs_log[0], mk(64'h5F80, 128, 0));
        check("post_rst_p3", hs_log[3], mk(64'h6200, 60, 1));
        drain();

        // Random requests, random backpressure, random responses, jittering MRRS
        mrrs_jitter = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rdy_pct = $urandom_range(100, 30);
            rsp_pct = $urandom_range(80, 20);
            send_req({32'($urandom_range(255)), 32'($urandom)},
                     $urandom_range(8191, 0), $urandom_range(7, 0));
            run_pieces(3000);
        end
        mrrs_jitter = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
